// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM states, strobe width and address-decode helpers.
// Used by both the APB master and every completer instance.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int APB_DATA_WIDTH = 32;
    localparam int STRB_W         = APB_DATA_WIDTH / 8;

    // Arguments are widened to 64 bits so BASE + 4*DEPTH cannot wrap for any legal ADDR_WIDTH.
    function automatic logic addr_err(input logic [63:0] paddr,
                                      input logic [63:0] base,
                                      input logic [63:0] depth);
        return (paddr[1:0] != 2'b00) || (paddr < base) || (paddr >= base + (depth << 2));
    endfunction

    function automatic logic [63:0] word_idx(input logic [63:0] paddr,
                                             input logic [63:0] base);
        return (paddr - base) >> 2;
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Word storage for the APB completer: synchronous clear, byte-enabled write port,
// combinational read port.
module apb_slave_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int IDX_W      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        widx_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic [IDX_W-1:0]        ridx_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int SW = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < SW; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with DEPTH words of byte-strobed memory, fixed wait states and
// PSLVERR on misaligned or out-of-window addresses.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int SW    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         strb_q, strb_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic                  setup_err;
    logic [IDX_W-1:0]      setup_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  mem_we;

    assign setup_err = addr_err(64'(PADDR), 64'(BASE_ADDR), 64'(DEPTH));
    assign setup_idx = IDX_W'(word_idx(64'(PADDR), 64'(BASE_ADDR)));
    // Zero-wait reads sample memory at the setup edge, before idx_q is loaded.
    assign rd_idx    = (state_q == IDLE) ? setup_idx : idx_q;

    apb_slave_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .we_i    (mem_we),
        .widx_i  (idx_q),
        .wdata_i (wdata_q),
        .wstrb_i (strb_q),
        .ridx_i  (rd_idx),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        err_d     = err_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    write_d = PWRITE;
                    err_d   = setup_err;
                    idx_d   = setup_idx;
                    wdata_d = PWDATA;
                    strb_d  = PSTRB;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = ACCESS;
                    if (WAIT_STATES == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = setup_err;
                        if (!PWRITE && !setup_err) begin
                            prdata_d = rd_data;
                        end
                    end
                end
            end
            ACCESS: begin
                if (!(PSEL && PENABLE)) begin
                    state_d = IDLE;
                end else if (pready_q) begin
                    mem_we  = write_q && !err_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        if (!write_q && !err_q) begin
                            prdata_d = rd_data;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            write_q   <= write_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign PREADY  = pready_q;
    assign PRDATA  = prdata_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three completers (0, 2 and 3 wait states) on one bus,
// checked every cycle against a transaction-level model plus literal expectations.
module tb_apb_slave_mem;

    localparam int DEPTH = 16;
    localparam int NI    = 3;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [2:0]  psel;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;

    logic        pready  [NI];
    logic [31:0] prdata  [NI];
    logic        pslverr [NI];

    logic        exp_ready [NI];
    logic [31:0] exp_rdata [NI];
    logic        exp_err   [NI];

    logic [31:0] mdl [NI][DEPTH];

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_slave_mem #(.WAIT_STATES(0)) u0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

    apb_slave_mem #(.WAIT_STATES(2)) u1 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

    apb_slave_mem #(.WAIT_STATES(3)) u2 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

    function automatic int ws_of(input int inst);
        case (inst)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge PCLK) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("u%0d.PREADY", i),  32'(pready[i]),  32'(exp_ready[i]));
                chk($sformatf("u%0d.PRDATA", i),  prdata[i],       exp_rdata[i]);
                chk($sformatf("u%0d.PSLVERR", i), 32'(pslverr[i]), 32'(exp_err[i]));
            end
        end
    end

    task automatic exp_zero();
        for (int i = 0; i < NI; i++) begin
            exp_ready[i] = 1'b0;
            exp_rdata[i] = '0;
            exp_err[i]   = 1'b0;
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < NI; i++)
            for (int w = 0; w < DEPTH; w++)
                mdl[i][w] = '0;
    endtask

    task automatic clear_drive();
        PRESET  = 1'b0;
        psel    = '0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        PSTRB   = '0;
    endtask

    task automatic idle_cycle();
        @(posedge PCLK); #1;
        clear_drive();
        exp_zero();
    endtask

    // One complete transfer; abort_at>0 drops PSEL in that access cycle.
    task automatic xfer(input int inst, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st, input int abort_at,
                        output logic [31:0] rd, output logic err_o, output int lat);
        int  ws;
        bit  e;
        int  idx;
        bit  aborted;
        ws      = ws_of(inst);
        e       = (addr % 4 != 0) || (addr >= 4 * DEPTH);
        idx     = (addr / 4) % DEPTH;
        aborted = 1'b0;
        rd      = '0;
        err_o   = 1'b0;
        lat     = 0;

        @(posedge PCLK); #1;
        clear_drive();
        psel[inst] = 1'b1;
        PWRITE     = wr;
        PADDR      = addr;
        PWDATA     = wd;
        PSTRB      = st;
        exp_zero();

        for (int k = 1; k <= ws + 1; k++) begin
            @(posedge PCLK); #1;
            PENABLE = 1'b1;
            if (k == abort_at) psel[inst] = 1'b0;
            exp_zero();
            if (k == ws + 1) begin
                exp_ready[inst] = 1'b1;
                exp_err[inst]   = e;
                exp_rdata[inst] = (!wr && !e) ? mdl[inst][idx] : 32'h0;
            end
            @(negedge PCLK);
            if (lat == 0 && pready[inst] === 1'b1) begin
                lat   = k;
                rd    = prdata[inst];
                err_o = pslverr[inst];
            end
            if (k == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end

        if (!aborted && wr && !e) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) mdl[inst][idx][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        clear_drive();
        PRESET = 1'b1;
        exp_zero();
        mdl_clear();
        repeat (3) @(posedge PCLK);
        #1 chk_en = 1'b1;
        idle_cycle();

        // Zero wait states: write then read back
        xfer(0, 1, 32'h08, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        chk("t1 write latency", 32'(lat), 32'd1);
        chk("t1 write err", 32'(er), 32'd0);
        xfer(0, 0, 32'h08, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t1 read data", rd, 32'hDEADBEEF);
        chk("t1 read latency", 32'(lat), 32'd1);

        // Partial strobes, back-to-back
        xfer(0, 1, 32'h04, 32'h11223344, 4'hF, 0, rd, er, lat);
        xfer(0, 1, 32'h04, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
        xfer(0, 0, 32'h04, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t2 strobe merge", rd, 32'h11BB33DD);

        // Three wait states
        idle_cycle();
        xfer(2, 0, 32'h00, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t3 read latency", 32'(lat), 32'd4);
        chk("t3 read data", rd, 32'h0);
        xfer(2, 1, 32'h00, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
        xfer(2, 0, 32'h00, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t3 readback", rd, 32'hCAFEF00D);

        // Error responses
        xfer(0, 0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t4 oob read err", 32'(er), 32'd1);
        chk("t4 oob read data", rd, 32'h0);
        xfer(0, 1, 32'h06, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
        chk("t4 misaligned write err", 32'(er), 32'd1);
        xfer(0, 0, 32'h04, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t4 memory unchanged", rd, 32'h11BB33DD);
        xfer(2, 0, 32'h44, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t4 oob err with waits", 32'(er), 32'd1);
        chk("t4 oob err latency", 32'(lat), 32'd4);
        xfer(0, 1, 32'h3C, 32'h0BADF00D, 4'hF, 0, rd, er, lat);
        chk("t4 last word ok", 32'(er), 32'd0);
        xfer(0, 1, 32'h3C, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat);
        chk("t4 zero strobe ok", 32'(er), 32'd0);
        xfer(0, 0, 32'h3C, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t4 last word data", rd, 32'h0BADF00D);

        // PENABLE without setup is ignored
        @(posedge PCLK); #1;
        clear_drive();
        psel[0] = 1'b1;
        PENABLE = 1'b1;
        PADDR   = 32'h08;
        exp_zero();
        idle_cycle();
        idle_cycle();

        // Abort in the 2nd access cycle
        xfer(1, 1, 32'h0C, 32'h55, 4'hF, 2, rd, er, lat);
        chk("t5 abort no ready", 32'(lat), 32'd0);
        idle_cycle();
        xfer(1, 0, 32'h0C, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t5 write discarded", rd, 32'h0);
        chk("t5 read latency", 32'(lat), 32'd3);

        // Reset during the access cycle of a write
        @(posedge PCLK); #1;
        clear_drive();
        psel[0] = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = 32'h10;
        PWDATA  = 32'h12345678;
        PSTRB   = 4'hF;
        exp_zero();
        @(posedge PCLK); #1;
        PENABLE      = 1'b1;
        PRESET       = 1'b1;
        exp_ready[0] = 1'b1;
        mdl_clear();
        xfer(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t6 write dropped", rd, 32'h0);
        xfer(0, 0, 32'h08, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t6 memory cleared", rd, 32'h0);
        xfer(0, 1, 32'h10, 32'h0000A5A5, 4'h3, 0, rd, er, lat);
        xfer(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t6 resume", rd, 32'h0000A5A5);

        idle_cycle();
        idle_cycle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB completer (slave) that answers the transfers issued by the team's APB master. It holds a byte-strobed word memory of DEPTH words behind one PSEL line, with a programmable number of wait states. It signals PSLVERR for misaligned or out-of-range addresses. One instance sits on each PSEL bit of the master; the master's slave-select address bit is stripped before PADDR reaches this block.

Parameters:
ADDR_WIDTH, 32, width of PADDR seen by the slave
DATA_WIDTH, 32, width of PWDATA/PRDATA; must be a multiple of 8
DEPTH, 16, number of DATA_WIDTH words stored
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned
WAIT_STATES, 0, extra access cycles before PREADY; legal range 0..15

Ports:
PCLK  input  1  clock; all logic on its rising edge
PRESET  input  1  reset; one clock, reset is synchronous and active-high
PSEL  input  1  slave select from the master
PENABLE  input  1  access-phase indicator
PWRITE  input  1  1 = write, 0 = read
PADDR  input  ADDR_WIDTH  byte address
PWDATA  input  DATA_WIDTH  write data
PSTRB  input  DATA_WIDTH/8  write byte lanes
PREADY  output  1  transfer completes in the current access cycle
PRDATA  output  DATA_WIDTH  read data; valid only while PREADY=1
PSLVERR  output  1  error response; valid only while PREADY=1

Behaviour:
- Reset (PRESET=1 at an edge): state IDLE; PREADY=0, PRDATA=0, PSLVERR=0; wait counter 0; all memory words cleared to 0. A transfer in flight is discarded and no write is committed.
- PREADY, PRDATA and PSLVERR are registered and driven low/zero whenever PREADY=0.
- FSM states: IDLE and ACCESS.
- IDLE: a setup phase is PSEL=1 and PENABLE=0. At that edge the block:
  - latches PADDR, PWRITE, PWDATA and PSTRB;
  - computes err = (PADDR[1:0]!=0) or (PADDR<BASE_ADDR) or (PADDR>=BASE_ADDR+4*DEPTH);
  - loads cnt<=WAIT_STATES and goes to ACCESS.
  - If WAIT_STATES==0, it also sets PREADY<=1 and PSLVERR<=err in the same edge. For a read with err=0 it sets PRDATA<=mem[idx]; otherwise PRDATA<=0.
  - PENABLE=1 seen in IDLE with no prior setup is ignored: stay in IDLE, PREADY stays 0.
- ACCESS, cnt>0 (PSEL=1, PENABLE=1): cnt<=cnt-1. When cnt==1, the block loads PREADY, PSLVERR and PRDATA as above on that edge.
- ACCESS, PREADY=1 (PSEL=1, PENABLE=1): the transfer completes at this edge.
  - A write with err=0 commits mem[idx] byte-wise: lane i is updated only if PSTRB[i]=1. PSTRB=0 writes nothing and still completes OKAY.
  - A write with err=1 changes no memory.
  - Next state IDLE; PREADY, PRDATA and PSLVERR return to 0.
- Latency: the access phase lasts exactly WAIT_STATES+1 cycles.
- Back-to-back transfers: the master re-enters setup in the cycle after completion; IDLE accepts it with no bubble.
- Abort: PSEL=0 or PENABLE=0 while in ACCESS sends the block to IDLE, clears the outputs and discards the write.
- Word index: idx = (PADDR-BASE_ADDR)>>2, using only the low clog2(DEPTH) bits.
- Reads ignore PSTRB. A read returns data committed by a write that completed in an earlier cycle.

Decomposition:
- Shared package apb_pkg holds:
  - the state enum {IDLE, ACCESS};
  - STRB_W = DATA_WIDTH/8;
  - a function addr_err(paddr, base, depth);
  - a function word_idx(paddr, base).
- The APB master reuses the same package for its address decode.
- One sub-module, apb_slave_regfile: DEPTH×DATA_WIDTH storage with synchronous reset, byte-enable write port and combinational read port. apb_slave_mem holds the FSM, wait counter, error check and output registers.

Test Plan:
1. WAIT_STATES=0: write 0xDEADBEEF to 0x08 with PSTRB=4'hF, then read 0x08 -> PREADY high in the first access cycle of each; PRDATA=0xDEADBEEF; PSLVERR=0.
2. Partial strobe: preload 0x11223344 at 0x04, write 0xAABBCCDD with PSTRB=4'b0101, read back -> PRDATA=0x11BB33DD.
3. WAIT_STATES=3: read 0x00 -> PREADY low for 3 access cycles and high on the 4th; PRDATA=0 before PREADY.
4. Errors: read 0x40 (DEPTH=16) and write 0x06 -> PREADY=1, PSLVERR=1, PRDATA=0; memory unchanged.
5. Abort: WAIT_STATES=2, write 0x55 to 0x0C, drop PSEL in the 2nd access cycle -> returns to IDLE; a later read of 0x0C gives 0x0.
6. Reset mid-transfer: assert PRESET during an access cycle of a write to 0x10 -> next cycle PREADY=0; read of 0x10 gives 0; back-to-back transfers resume with no idle cycle.
